// File: rtl/ui_pkg.sv
// Shared user-interface constants: seven-segment glyphs and digit-index sizing.
package ui_pkg;

    localparam int unsigned DEF_DIGITS = 8;
    localparam logic [6:0]  SEG_OFF    = 7'h00;

    // Active-high {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int unsigned idx_w(int unsigned digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_w(DEF_DIGITS);

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load-side inputs and pin-side outputs of the multiplexed seven-segment driver.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 8
);
    logic [4*DIGITS-1:0] i_data;
    logic [DIGITS-1:0]   i_dp;
    logic [DIGITS-1:0]   i_blank;
    logic                i_load;
    logic [DIGITS-1:0]   o_anode;
    logic [6:0]          o_seg;
    logic                o_dp;
    logic                o_frame;

    modport master (
        output i_data, i_dp, i_blank, i_load,
        input  o_anode, o_seg, o_dp, o_frame
    );

    modport slave (
        input  i_data, i_dp, i_blank, i_load,
        output o_anode, o_seg, o_dp, o_frame
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg7
    import ui_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_HEX[nib_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver; new values take effect only at frame ends.
module seg7_scan_driver
    import ui_pkg::*;
#(
    parameter int unsigned DIGITS     = DEF_DIGITS,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLANK_CYC  = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned IDX_W = idx_w(DIGITS);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    localparam logic [DIGITS-1:0] ANODE_OFF   = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_PIN_OFF = SEG_OFF ^ {7{ACTIVE_LOW}};

    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_q, frame_d;

    logic                wrap;
    logic                boundary;
    logic [3:0]          cur_nib;
    logic [6:0]          cur_seg;
    logic [DIGITS-1:0]   anode_on;

    assign wrap     = (div_q == DIV_W'(SCAN_DIV - 1));
    assign boundary = wrap && (idx_q == IDX_W'(DIGITS - 1));
    assign cur_nib  = act_data_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib_i (cur_nib),
        .seg_o (cur_seg)
    );

    always_comb begin
        div_d        = wrap ? '0 : div_q + 1'b1;
        idx_d        = idx_q;
        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        frame_d      = 1'b0;

        if (wrap) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        if (bus.i_load) begin
            pend_data_d  = bus.i_data;
            pend_dp_d    = bus.i_dp;
            pend_blank_d = bus.i_blank;
            pend_d       = 1'b1;
        end

        // A load in the boundary cycle flows straight through to the active set.
        if (boundary && pend_d) begin
            act_data_d  = pend_data_d;
            act_dp_d    = pend_dp_d;
            act_blank_d = pend_blank_d;
            pend_d      = 1'b0;
            frame_d     = 1'b1;
        end

        anode_on = '0;
        if ((div_q >= DIV_W'(BLANK_CYC)) && !act_blank_q[idx_q]) begin
            anode_on[idx_q] = 1'b1;
        end
        anode_d = anode_on ^ ANODE_OFF;
        seg_d   = cur_seg ^ {7{ACTIVE_LOW}};
        dp_d    = act_dp_q[idx_q] ^ ACTIVE_LOW;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            anode_q      <= ANODE_OFF;
            seg_q        <= SEG_PIN_OFF;
            dp_q         <= ACTIVE_LOW;
            frame_q      <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.o_anode = anode_q;
    assign bus.o_seg   = seg_q;
    assign bus.o_dp    = dp_q;
    assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded random test of seg7_scan_driver plus a directed active-low 4-digit check.
module tb_seg7_scan_driver;

    localparam int S = 8;
    localparam int B = 2;
    localparam int D = 8;
    localparam int F = S * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver_if #(.DIGITS(8)) a_if ();
    seg7_scan_driver_if #(.DIGITS(4)) b_if ();

    seg7_scan_driver #(
        .DIGITS(8), .SCAN_DIV(S), .BLANK_CYC(B), .ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (a_if)
    );

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(S), .BLANK_CYC(B), .ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b_if)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned tm;
    logic [31:0] m_pdata, m_adata;
    logic [7:0]  m_pdp, m_adp, m_pbl, m_abl;
    logic        m_pf;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    // Reference: position in the frame follows from the cycle count since reset.
    task automatic model_step();
        int   pos;
        int   dig;
        exp_t e;
        pos   = int'(tm % S);
        dig   = int'((tm / S) % D);
        e.an  = '0;
        if (pos >= B && !m_abl[dig]) e.an[dig] = 1'b1;
        e.seg = glyph(m_adata[dig*4 +: 4]);
        e.dp  = m_adp[dig];
        e.fr  = 1'b0;
        if (a_if.i_load) begin
            m_pdata = a_if.i_data;
            m_pdp   = a_if.i_dp;
            m_pbl   = a_if.i_blank;
            m_pf    = 1'b1;
        end
        if ((tm % F) == F - 1 && m_pf) begin
            m_adata = m_pdata;
            m_adp   = m_pdp;
            m_abl   = m_pbl;
            m_pf    = 1'b0;
            e.fr    = 1'b1;
        end
        exp_q.push_back(e);
        tm++;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            tm      = 0;
            m_pdata = '0;
            m_adata = '0;
            m_pdp   = '0;
            m_adp   = '0;
            m_pbl   = '1;
            m_abl   = '1;
            m_pf    = 1'b0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("scan {anode,seg,dp,frame}",
                  32'({a_if.o_anode, a_if.o_seg, a_if.o_dp, a_if.o_frame}), 32'(mon_e));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        a_if.i_data  = d;
        a_if.i_dp    = dp;
        a_if.i_blank = bl;
        a_if.i_load  = 1'b1;
        tick(1);
        a_if.i_load  = 1'b0;
    endtask

    task automatic wait_phase(input int unsigned ph);
        int n;
        n = 0;
        while ((tm % F) != ph && n < 3 * F) begin
            tick(1);
            n++;
        end
        if ((tm % F) != ph) begin
            total++;
            bad++;
            $display("FAIL phase wait: got %0d want %0d", tm % F, ph);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [6:0] want7;
        a_if.i_data = '0;  a_if.i_dp = '0;  a_if.i_blank = '0;  a_if.i_load = 1'b0;
        b_if.i_data = '0;  b_if.i_dp = '0;  b_if.i_blank = '0;  b_if.i_load = 1'b0;

        tick(2);
        check("reset outputs A", 32'({a_if.o_anode, a_if.o_seg, a_if.o_dp, a_if.o_frame}), 32'h0);
        check("reset outputs B", 32'({b_if.o_anode, b_if.o_seg, b_if.o_dp, b_if.o_frame}),
              32'({4'hF, 7'h7F, 1'b1, 1'b0}));
        rst = 1'b0;
        tick(100);

        load_a(32'h0123_4567, 8'h00, 8'h00);
        tick(140);

        // Asynchronous reset while an anode is lit.
        n = 0;
        while (a_if.o_anode == 8'h00 && n < 2 * F) begin
            tick(1);
            n++;
        end
        check("anode lit before reset", 32'(a_if.o_anode != 8'h00), 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset A", 32'({a_if.o_anode, a_if.o_seg, a_if.o_dp, a_if.o_frame}), 32'h0);
        check("async reset B", 32'({b_if.o_anode, b_if.o_seg, b_if.o_dp, b_if.o_frame}),
              32'({4'hF, 7'h7F, 1'b1, 1'b0}));
        tick(2);
        rst = 1'b0;
        tick(80);

        load_a(32'h0123_4567, 8'h00, 8'h00);
        tick(100);

        wait_phase(20);
        load_a(32'h1111_1111, 8'h00, 8'h00);
        tick(3);
        load_a(32'h2222_2222, 8'h00, 8'h00);
        tick(140);

        wait_phase(F - 1);
        load_a($urandom, 8'h00, 8'h00);
        tick(140);

        load_a($urandom, 8'h01, 8'hF0);
        tick(140);

        for (int i = 0; i < 20; i++) begin
            load_a($urandom, 8'($urandom), 8'($urandom));
            tick($urandom_range(0, 90));
        end
        tick(140);

        // Active-low, 4-digit instance.
        check("B idle anodes", 32'(b_if.o_anode), 32'hF);
        b_if.i_data  = 16'hABCD;
        b_if.i_load  = 1'b1;
        tick(1);
        b_if.i_load  = 1'b0;
        n = 0;
        while (b_if.o_frame !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("B frame pulse", 32'(b_if.o_frame), 32'h1);
        n = 0;
        while (b_if.o_anode !== 4'hE && n < 100) begin
            tick(1);
            n++;
        end
        want7 = ~glyph(4'hD);
        check("B digit0 anode", 32'(b_if.o_anode), 32'hE);
        check("B digit0 seg", 32'(b_if.o_seg), 32'(want7));
        check("B digit0 dp off", 32'(b_if.o_dp), 32'h1);
        n = 0;
        while (b_if.o_anode === 4'hE && n < 20) begin
            tick(1);
            n++;
        end
        check("B gap anodes", 32'(b_if.o_anode), 32'hF);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
